// File: rtl/stack_arbiter.sv
// Purpose : round-robin arbiter that shares one LIFO stack between requesters A and B.
// Latency : gnt 1 cycle after the IDLE sampling edge; rvalid 2 cycles after it (push/error) or 3 (pop).
// Backpr. : requests are held by the client until gnt; one operation in flight, IDLE ignores nothing else.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   a_req/a_op/a_wdata             A request, op (1=push, 0=pop), push data
//   a_gnt/a_rvalid/a_rdata/a_err   A accept pulse, response pulse, pop data, rejected flag
//   b_*                            same set for requester B
//   stk_push/stk_pop/stk_data_in   strobes and push data driven to the stack
//   stk_data_out/stk_full/stk_empty stack read data (registered) and status flags
//   busy                           FSM not in IDLE
//   err_count                      saturating count of rejected operations
module stack_arbiter #(
   parameter int WIDTH     = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_req,
   input  logic                 a_op,
   input  logic [WIDTH-1:0]     a_wdata,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [WIDTH-1:0]     a_rdata,
   output logic                 a_err,
   input  logic                 b_req,
   input  logic                 b_op,
   input  logic [WIDTH-1:0]     b_wdata,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [WIDTH-1:0]     b_rdata,
   output logic                 b_err,
   output logic                 stk_push,
   output logic                 stk_pop,
   output logic [WIDTH-1:0]     stk_data_in,
   input  logic [WIDTH-1:0]     stk_data_out,
   input  logic                 stk_full,
   input  logic                 stk_empty,
   output logic                 busy,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  sel_q, sel_d;      // 0 = A, 1 = B
   logic                  op_q, op_d;        // 1 = push, 0 = pop
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic                  rr_q, rr_d;        // side that wins the next tie
   logic [WIDTH-1:0]      a_rdata_q, a_rdata_d;
   logic [WIDTH-1:0]      b_rdata_q, b_rdata_d;
   logic                  a_err_q, a_err_d;
   logic                  b_err_q, b_err_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic                  reject;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      op_d      = op_q;
      wdata_d   = wdata_q;
      rr_d      = rr_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      a_err_d   = a_err_q;
      b_err_d   = b_err_q;
      err_cnt_d = err_cnt_q;
      reject    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               // Tie goes to the pointer; otherwise whoever is asking.
               if (a_req && b_req) begin
                  sel_d = rr_q;
               end else begin
                  sel_d = ~a_req;
               end
               op_d    = sel_d ? b_op    : a_op;
               wdata_d = sel_d ? b_wdata : a_wdata;
               rr_d    = ~sel_d;
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            // Flags are only trusted in this cycle; the decision is final here.
            reject = op_q ? stk_full : stk_empty;
            if (!sel_q) begin
               a_err_d = reject;
               if (reject || op_q) begin
                  a_rdata_d = '0;
               end
            end else begin
               b_err_d = reject;
               if (reject || op_q) begin
                  b_rdata_d = '0;
               end
            end
            if (reject && (err_cnt_q != '1)) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            state_d = (!op_q && !reject) ? S_WAIT : S_RESP;
         end

         S_WAIT: begin
            // Stack output is registered: it holds the popped word now.
            if (!sel_q) begin
               a_rdata_d = stk_data_out;
            end else begin
               b_rdata_d = stk_data_out;
            end
            state_d = S_RESP;
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sel_q     <= 1'b0;
         op_q      <= 1'b0;
         wdata_q   <= '0;
         rr_q      <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         op_q      <= op_d;
         wdata_q   <= wdata_d;
         rr_q      <= rr_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign a_gnt       = (state_q == S_ISSUE) && !sel_q;
   assign b_gnt       = (state_q == S_ISSUE) &&  sel_q;
   assign a_rvalid    = (state_q == S_RESP)  && !sel_q;
   assign b_rvalid    = (state_q == S_RESP)  &&  sel_q;
   assign a_rdata     = a_rdata_q;
   assign b_rdata     = b_rdata_q;
   assign a_err       = a_err_q;
   assign b_err       = b_err_q;
   // Strobes are qualified by the live flags so a blocked op never touches the stack.
   assign stk_push    = (state_q == S_ISSUE) &&  op_q && !stk_full;
   assign stk_pop     = (state_q == S_ISSUE) && !op_q && !stk_empty;
   assign stk_data_in = stk_push ? wdata_q : '0;
   assign busy        = (state_q != S_IDLE);
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_stack_arbiter.sv
`timescale 1ns/1ps
module tb_stack_arbiter;
   localparam int W     = 8;
   localparam int ECW   = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          a_req = 1'b0, a_op = 1'b0;
   logic [W-1:0]  a_wdata = '0;
   logic          b_req = 1'b0, b_op = 1'b0;
   logic [W-1:0]  b_wdata = '0;
   logic          a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [W-1:0]  a_rdata, b_rdata;
   logic          stk_push, stk_pop, stk_full, stk_empty, busy;
   logic [W-1:0]  stk_data_in, stk_data_out;
   logic [ECW-1:0] err_count;

   stack_arbiter #(.WIDTH(W), .ERR_CNT_W(ECW)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
      .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty),
      .busy(busy), .err_count(err_count)
   );

   // Environment stack: the physical LIFO the arbiter drives.
   logic [W-1:0] mem [DEPTH];
   logic [2:0]   sp;
   assign stk_full  = (sp == 3'd4);
   assign stk_empty = (sp == 3'd0);
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp <= 3'd0;
         stk_data_out <= '0;
      end else if (stk_push && !stk_full) begin
         mem[sp[1:0]] <= stk_data_in;
         sp <= sp + 3'd1;
      end else if (stk_pop && !stk_empty) begin
         stk_data_out <= mem[sp[1:0] - 2'd1];
         sp <= sp - 3'd1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input string why);
      n_chk++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
   endtask

   // Reference model: plain LIFO semantics, tie pointer, saturating counter.
   typedef struct {
      logic         side;
      logic         op;
      logic [W-1:0] wdata;
      logic         err;
      logic [W-1:0] rdata;
      logic [ECW-1:0] cnt;
   } exp_t;

   exp_t         gnt_q[$];
   exp_t         rsp_q[$];
   int           rsp_due[$];
   logic [W-1:0] ref_stk[$];
   logic         ref_rr = 1'b0;
   int           ref_cnt = 0;

   function automatic exp_t model(input logic side, input logic op, input logic [W-1:0] d);
      exp_t e;
      e.side = side; e.op = op; e.wdata = d; e.err = 1'b0; e.rdata = '0;
      if (op) begin
         if (ref_stk.size() == DEPTH) e.err = 1'b1;
         else ref_stk.push_back(d);
      end else begin
         if (ref_stk.size() == 0) e.err = 1'b1;
         else e.rdata = ref_stk.pop_back();
      end
      if (e.err && ref_cnt < (1 << ECW) - 1) ref_cnt++;
      e.cnt = ECW'(ref_cnt);
      ref_rr = ~side;
      return e;
   endfunction

   // Monitor: grants and responses checked against the scoreboard queues.
   always @(negedge clk) begin
      if (rst) begin
         if (!(a_gnt || b_gnt) && (stk_push || stk_pop))
            flag("stray_strobe", "stack strobe outside a grant cycle");
         if (a_gnt || b_gnt) begin
            chk("single_gnt", 32'(a_gnt & b_gnt), 0);
            if (gnt_q.size() == 0) begin
               flag("unexpected_gnt", "grant with no pending request");
            end else begin
               exp_t e;
               e = gnt_q.pop_front();
               chk("gnt_side", 32'(b_gnt), 32'(e.side));
               chk("stk_push", 32'(stk_push), 32'(e.op && !e.err));
               chk("stk_pop", 32'(stk_pop), 32'(!e.op && !e.err));
               if (e.op && !e.err) chk("stk_data_in", 32'(stk_data_in), 32'(e.wdata));
               rsp_q.push_back(e);
               rsp_due.push_back(cyc + ((!e.op && !e.err) ? 2 : 1));
            end
         end
         if (a_rvalid || b_rvalid) begin
            chk("single_rvalid", 32'(a_rvalid & b_rvalid), 0);
            if (rsp_q.size() == 0) begin
               flag("unexpected_rvalid", "response with nothing outstanding");
            end else begin
               exp_t e;
               int due;
               e = rsp_q.pop_front();
               due = rsp_due.pop_front();
               chk("rvalid_side", 32'(b_rvalid), 32'(e.side));
               chk("rdata", 32'(e.side ? b_rdata : a_rdata), 32'(e.rdata));
               chk("err", 32'(e.side ? b_err : a_err), 32'(e.err));
               chk("err_count", 32'(err_count), 32'(e.cnt));
               chk("latency", 32'(cyc), 32'(due));
            end
         end else if (rsp_q.size() != 0 && cyc > rsp_due[0]) begin
            flag("rvalid_timeout", "response not seen in time");
            void'(rsp_q.pop_front());
            void'(rsp_due.pop_front());
         end
      end
   end

   // One transaction round: A and/or B request together, each drops req on its gnt.
   task automatic txn(input logic da, input logic db, input logic oa, input logic ob,
                      input logic [W-1:0] wa, input logic [W-1:0] wb);
      logic pa, pb, first;
      int t;
      @(posedge clk); #1;
      if (da && db) begin
         first = ref_rr;
         gnt_q.push_back(model(first, first ? ob : oa, first ? wb : wa));
         gnt_q.push_back(model(~first, first ? oa : ob, first ? wa : wb));
      end else if (da) begin
         gnt_q.push_back(model(1'b0, oa, wa));
      end else if (db) begin
         gnt_q.push_back(model(1'b1, ob, wb));
      end
      a_req = da; a_op = oa; a_wdata = wa;
      b_req = db; b_op = ob; b_wdata = wb;
      pa = da; pb = db; t = 0;
      while ((pa || pb) && t < 40) begin
         @(negedge clk); t++;
         if (a_gnt) begin a_req = 1'b0; pa = 1'b0; end
         if (b_gnt) begin b_req = 1'b0; pb = 1'b0; end
      end
      if (pa || pb) flag("gnt_timeout", "request never granted");
      a_req = 1'b0; b_req = 1'b0;
      t = 0;
      while ((gnt_q.size() != 0 || rsp_q.size() != 0) && t < 40) begin
         @(negedge clk); t++;
      end
      if (gnt_q.size() != 0 || rsp_q.size() != 0) begin
         flag("drain_timeout", "outstanding operations never completed");
         gnt_q.delete(); rsp_q.delete(); rsp_due.delete();
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_a_out"}, 32'({a_gnt, a_rvalid, a_rdata, a_err}), 0);
      chk({tag, "_b_out"}, 32'({b_gnt, b_rvalid, b_rdata, b_err}), 0);
      chk({tag, "_stk_out"}, 32'({stk_push, stk_pop, stk_data_in}), 0);
      chk({tag, "_busy_cnt"}, 32'({busy, err_count}), 0);
   endtask

   initial begin
      int t;
      // 1. reset state and a single push
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("in_reset");
      rst = 1'b1;
      @(negedge clk);
      check_quiet("after_release");
      txn(1, 0, 1, 0, 8'hAA, 8'h00);

      // 2. LIFO order across requesters
      txn(0, 1, 0, 1, 8'h00, 8'hBB);
      txn(1, 0, 0, 0, 8'h00, 8'h00);
      txn(0, 1, 0, 0, 8'h00, 8'h00);

      // 4. underflow, then fill and overflow
      txn(1, 0, 0, 0, 8'h00, 8'h00);
      for (int i = 0; i < DEPTH; i++) txn(i[0], ~i[0], 1, 1, W'(8'h10 + i), W'(8'h20 + i));
      txn(0, 1, 1, 1, 8'h00, 8'hEE);

      // 5. reset during WAIT of a pop
      @(posedge clk); #1;
      gnt_q.push_back(model(1'b0, 1'b0, '0));
      a_req = 1'b1; a_op = 1'b0;
      t = 0;
      while (!a_gnt && t < 20) begin @(negedge clk); t++; end
      if (!a_gnt) flag("rst_test_gnt", "pop never granted");
      a_req = 1'b0;
      @(negedge clk);
      chk("wait_busy", 32'(busy), 1);
      #2 rst = 1'b0;
      #1 check_quiet("async_rst");
      gnt_q.delete(); rsp_q.delete(); rsp_due.delete();
      ref_stk.delete(); ref_rr = 1'b0; ref_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      txn(1, 1, 1, 1, 8'h31, 8'h32);
      txn(1, 1, 0, 0, 8'h00, 8'h00);

      // 6. saturate the error counter
      for (int i = 0; i < 5; i++) txn(i[0], ~i[0], 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      chk("err_cnt_sat", 32'(err_count), 3);

      // 3. both requesting: grants alternate
      for (int i = 0; i < 4; i++) txn(1, 1, i < 2, i < 2, W'($urandom), W'($urandom));

      // random mix
      for (int i = 0; i < 60; i++) begin
         logic da, db;
         da = 1'($urandom_range(0, 1));
         db = 1'($urandom_range(0, 1));
         if (!da && !db) da = 1'b1;
         txn(da, db, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             W'($urandom), W'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
